ntt_stage_ctrl: RTL and testbench
=================================

Name: ntt_stage_ctrl

Overview:
- Sequencer that runs a complete in-place forward NTT (Cooley-Tukey, natural-order input, bit-reversed output) over an N-point coefficient memory using one butterfly unit.
- Generates dual read addresses and the twiddle ROM address, and drives the BFU mode.
- Delays the address pair so the BFU's out0/out1 results are written back to the same addresses.
- Data flows memory → BFU → memory outside this block; this block carries only control and addresses.

Parameters:
- logn, 8, log2 of the transform size N (N = 2^logn, N/2 butterflies per stage)
- dm, 4, multiplier latency inside the BFU; must match the BFU instance
- PIPE, 3*dm+3 (localparam), issue-to-writeback latency: 1 memory-read cycle + 3*dm+1 mul_red cycles + 1 BFU output register

Ports:
- clk, input, 1, clock; all state updates on the rising edge
- rst, input, 1, asynchronous active-high reset
- start, input, 1, begin a transform; sampled only in IDLE
- busy, output, 1, high from the cycle after start is accepted until done
- done, output, 1, one-cycle pulse when the last writeback has completed
- rd_en, output, 1, issue strobe for the dual-port coefficient read
- rd_addr0, output, logn, address of coefficient u (top of butterfly)
- rd_addr1, output, logn, address of coefficient v (bottom of butterfly)
- tw_addr, output, logn, twiddle ROM index; ROM read latency is 1, aligned with the coefficient read
- bfu_mode, output, 2, constant 2'b00 (butterfly)
- wr_en, output, 1, writeback strobe for BFU out0→wr_addr0 and out1→wr_addr1
- wr_addr0, output, logn, rd_addr0 delayed by PIPE cycles
- wr_addr1, output, logn, rd_addr1 delayed by PIPE cycles

Behaviour:
- Reset: asynchronous. All outputs go to 0 immediately (bfu_mode 2'b00), FSM → IDLE, counters and all delay-line valids cleared. A reset mid-transform aborts it with no further wr_en; memory contents are undefined afterwards.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when start=1. busy is high from the next cycle; stage counter s=0, butterfly counter k=0.
  - RUN: rd_en=1 each cycle, then k increments. When k = N/2-1, clear k and go to DRAIN with drain counter = 0.
  - DRAIN: rd_en=0 for PIPE cycles, which covers the cycle in which the last wr_en of the stage fires. Then go to RUN with s+1, or to DONE if s = logn-1. Draining guarantees no read-after-write hazard across stages.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. start is ignored in RUN, DRAIN and DONE; start in DONE is not queued.
- Address generation for stage s and butterfly k, combinational from the registers:
  - h = logn-1-s, len = 2^h, grp = k>>h, off = k & (len-1)
  - rd_addr0 = (grp<<(h+1)) | off
  - rd_addr1 = rd_addr0 + len
  - tw_addr = 2^s + grp, which is always < N
  - All three are 0 when rd_en=0.
- Writeback:
  - A PIPE-deep shift register carries {valid, addr0, addr1}.
  - wr_en(t+PIPE) = rd_en(t); wr_addr0/1 carry the issuing cycle's addresses.
  - When wr_en=0, wr_addr0/1 are 0.
- Throughput: one butterfly per cycle within a stage.
- Total latency: start accepted in cycle 0 → first rd_en in cycle 1 → done in cycle 1 + logn*(N/2 + PIPE).

Test Plan:
- Reset defaults (logn=3, dm=4, PIPE=15): hold rst, then release → all outputs 0, busy=0. Assert rst mid-RUN → outputs drop to 0 in the same cycle without waiting for a clock; later writes in flight never appear.
- Stage 0 addressing: start at cycle 0 → rd_en cycles 1-4; rd pairs (0,4),(1,5),(2,6),(3,7); tw_addr 1,1,1,1.
- Later stages:
  - Stage 1 issues in cycles 20-23: pairs (0,2),(1,3),(4,6),(5,7); tw 2,2,3,3.
  - Stage 2 issues in cycles 39-42: pairs (0,1),(2,3),(4,5),(6,7); tw 4,5,6,7.
- Writeback alignment: wr_en in cycles 16-19, 35-38 and 54-57, with addresses equal to the reads issued 15 cycles earlier. done pulses at cycle 58, then busy=0; no write overlaps any read of the following stage.
- Start handling: pulse start during RUN and during DONE → ignored, no restart, schedule unchanged. start in the cycle after DONE → new run begins normally.
- End-to-end check: connect the coefficient RAM, twiddle ROM and BFU (q=7681, logn=8). Load a[i]=i and run → memory matches the golden bit-reversed-output NTT; done at cycle 1 + 8*(128+15) = 1145.

Source files
------------

// File: rtl/ntt_stage_ctrl_if.sv
// Control/address bundle between the NTT sequencer and the memory/BFU datapath.
interface ntt_stage_ctrl_if #(
  parameter int unsigned logn = 8
);
  logic            start;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [logn-1:0] rd_addr0;
  logic [logn-1:0] rd_addr1;
  logic [logn-1:0] tw_addr;
  logic [1:0]      bfu_mode;
  logic            wr_en;
  logic [logn-1:0] wr_addr0;
  logic [logn-1:0] wr_addr1;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr0, rd_addr1, tw_addr, bfu_mode,
    output wr_en, wr_addr0, wr_addr1
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr0, rd_addr1, tw_addr, bfu_mode,
    input  wr_en, wr_addr0, wr_addr1
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// In-place forward NTT sequencer: issues one butterfly per cycle per stage, drains the BFU
// pipeline between stages and replays the read addresses as write addresses PIPE cycles later.
module ntt_stage_ctrl #(
  parameter int unsigned logn = 8,
  parameter int unsigned dm   = 4
) (
  input logic             clk,
  input logic             rst,
  ntt_stage_ctrl_if.master bus
);
  localparam int unsigned PIPE = 3 * dm + 3;
  localparam int unsigned Half = 1 << (logn - 1);
  localparam int unsigned SW   = (logn > 1) ? $clog2(logn) : 1;
  localparam int unsigned CW   = $clog2(PIPE);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q;
  logic [SW-1:0]   s_q;
  logic [logn-1:0] k_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q, rd_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
            s_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
          end
        end
        StRun: begin
          if (k_q == logn'(Half - 1)) begin
            k_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            k_q <= k_q + logn'(1);
          end
        end
        StDrain: begin
          // Stay quiet until the stage's last writeback has landed (no RAW across stages).
          if (cnt_q == CW'(PIPE - 1)) begin
            if (s_q == SW'(logn - 1)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              s_q     <= s_q + SW'(1);
              rd_en_q <= 1'b1;
              state_q <= StRun;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Butterfly k of stage s: span len = 2^(logn-1-s), group grp, offset off within the group.
  logic [SW-1:0]   h;
  logic [logn-1:0] len, grp, off, a0, a1, tw;

  always_comb begin
    h   = SW'(logn - 1) - s_q;
    len = logn'(1) << h;
    grp = k_q >> h;
    off = k_q & (len - logn'(1));
    a0  = ((grp << h) << 1) | off;
    a1  = a0 + len;
    tw  = (logn'(1) << s_q) + grp;
  end

  logic [PIPE-1:0] vld_q;
  logic [logn-1:0] dl0_q [PIPE];
  logic [logn-1:0] dl1_q [PIPE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        dl0_q[i] <= '0;
        dl1_q[i] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[PIPE-2:0], rd_en_q};
      dl0_q[0] <= rd_en_q ? a0 : '0;
      dl1_q[0] <= rd_en_q ? a1 : '0;
      for (int i = 1; i < PIPE; i++) begin
        dl0_q[i] <= dl0_q[i-1];
        dl1_q[i] <= dl1_q[i-1];
      end
    end
  end

  always_comb begin
    bus.busy     = busy_q;
    bus.done     = done_q;
    bus.rd_en    = rd_en_q;
    bus.rd_addr0 = rd_en_q ? a0 : '0;
    bus.rd_addr1 = rd_en_q ? a1 : '0;
    bus.tw_addr  = rd_en_q ? tw : '0;
    bus.bfu_mode = 2'b00;
    bus.wr_en    = vld_q[PIPE-1];
    bus.wr_addr0 = vld_q[PIPE-1] ? dl0_q[PIPE-1] : '0;
    bus.wr_addr1 = vld_q[PIPE-1] ? dl1_q[PIPE-1] : '0;
  end
endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: per-cycle schedule built from the Cooley-Tukey loop nest,
// randomised start noise, idle gaps and a mid-run asynchronous reset.
module tb_ntt_stage_ctrl;
  localparam int LOGN  = 3;
  localparam int DM    = 4;
  localparam int PIPE  = 3 * DM + 3;
  localparam int N     = 1 << LOGN;
  localparam int HALF  = N / 2;
  localparam int TOTAL = 1 + LOGN * (HALF + PIPE);
  localparam int MAXC  = TOTAL + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_stage_ctrl_if #(.logn(LOGN)) bus ();

  ntt_stage_ctrl #(.logn(LOGN), .dm(DM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs indexed by cycle number relative to the start-accept cycle (0).
  int e_rd [MAXC];
  int e_a0 [MAXC];
  int e_a1 [MAXC];
  int e_tw [MAXC];
  int e_wr [MAXC];
  int e_w0 [MAXC];
  int e_w1 [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string where);
    chk({where, ".busy"}, 32'(bus.busy), 0);
    chk({where, ".done"}, 32'(bus.done), 0);
    chk({where, ".rd_en"}, 32'(bus.rd_en), 0);
    chk({where, ".rd_addr0"}, 32'(bus.rd_addr0), 0);
    chk({where, ".rd_addr1"}, 32'(bus.rd_addr1), 0);
    chk({where, ".tw_addr"}, 32'(bus.tw_addr), 0);
    chk({where, ".bfu_mode"}, 32'(bus.bfu_mode), 0);
    chk({where, ".wr_en"}, 32'(bus.wr_en), 0);
    chk({where, ".wr_addr0"}, 32'(bus.wr_addr0), 0);
    chk({where, ".wr_addr1"}, 32'(bus.wr_addr1), 0);
  endtask

  task automatic chk_cycle(input int t);
    string p;
    p = $sformatf("c%0d", t);
    chk({p, ".busy"}, 32'(bus.busy), 32'(t >= 1 && t < TOTAL));
    chk({p, ".done"}, 32'(bus.done), 32'(t == TOTAL));
    chk({p, ".rd_en"}, 32'(bus.rd_en), e_rd[t]);
    chk({p, ".rd_addr0"}, 32'(bus.rd_addr0), e_a0[t]);
    chk({p, ".rd_addr1"}, 32'(bus.rd_addr1), e_a1[t]);
    chk({p, ".tw_addr"}, 32'(bus.tw_addr), e_tw[t]);
    chk({p, ".bfu_mode"}, 32'(bus.bfu_mode), 0);
    chk({p, ".wr_en"}, 32'(bus.wr_en), e_wr[t]);
    chk({p, ".wr_addr0"}, 32'(bus.wr_addr0), e_w0[t]);
    chk({p, ".wr_addr1"}, 32'(bus.wr_addr1), e_w1[t]);
  endtask

  // Full transform; noise pulses start randomly while it must be ignored.
  // abort_at > 0 asserts reset right after checking that cycle.
  task automatic run(input bit noise, input int abort_at);
    @(negedge clk);
    chk("idle.busy", 32'(bus.busy), 0);
    chk("idle.done", 32'(bus.done), 0);
    bus.start = 1'b1;
    for (int t = 1; t <= TOTAL; t++) begin
      @(negedge clk);
      chk_cycle(t);
      bus.start = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (t == abort_at) begin
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        chk_quiet("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < PIPE + 3; i++) begin
          @(negedge clk);
          chk_quiet("post_abort");
        end
        return;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk_quiet("gap");
    end
  endtask

  initial begin
    int c;
    int len;
    bus.start = 1'b0;

    // Reference schedule from the textbook loop nest: stage s pairs (j, j+len) per block.
    c = 1;
    for (int s = 0; s < LOGN; s++) begin
      len = N >> (s + 1);
      for (int base = 0; base < N; base += 2 * len) begin
        for (int j = 0; j < len; j++) begin
          e_rd[c]        = 1;
          e_a0[c]        = base + j;
          e_a1[c]        = base + j + len;
          e_tw[c]        = (1 << s) + base / (2 * len);
          e_wr[c + PIPE] = 1;
          e_w0[c + PIPE] = base + j;
          e_w1[c + PIPE] = base + j + len;
          c++;
        end
      end
      c += PIPE;
    end

    #1;
    chk_quiet("reset_hold");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("after_reset");

    run(1'b0, 0);
    run(1'b1, 0);
    gap($urandom_range(0, 3));
    run(1'b1, $urandom_range(2, TOTAL - 20));
    gap($urandom_range(0, 3));
    run(1'b1, 0);
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
